// File: rtl/encoder_pkg.sv
// encoder_pkg
// Shared definitions for the priority-encoder family.
//   MODE_FIXED / MODE_RR : encodings of the 'mode' input.
//   wrap_dec(value, n)   : decrement modulo n. Zero wraps to n-1, not to
//                          the all-ones value of the index width.
package encoder_pkg;

  localparam logic MODE_FIXED = 1'b0;
  localparam logic MODE_RR    = 1'b1;

  function automatic int unsigned wrap_dec(input int unsigned value,
                                           input int unsigned n);
    return (value == 0) ? (n - 1) : (value - 1);
  endfunction

endpackage

// File: rtl/prio_scan.sv
// prio_scan
// Purely combinational scan that returns the highest set bit of a vector.
//   in_vec : N-bit input vector
//   idx    : index of the highest set bit (0 when nothing is set)
//   any    : 1 when at least one bit of in_vec is set
module prio_scan #(
  parameter int N = 8
) (
  input  logic [N-1:0]         in_vec,
  output logic [$clog2(N)-1:0] idx,
  output logic                 any
);

  localparam int W = $clog2(N);

  // Ascending loop, so the last set bit seen is the highest one.
  always_comb begin
    idx = '0;
    any = 1'b0;
    for (int i = 0; i < N; i++) begin
      if (in_vec[i]) begin
        idx = W'(i);
        any = 1'b1;
      end
    end
  end

endmodule

// File: rtl/prio_encoder_rr.sv
// prio_encoder_rr
// Registered N-to-log2(N) priority encoder with fixed and round-robin modes.
//   clk        : rising-edge clock
//   rst        : asynchronous active-high reset
//   en         : sample strobe; req and mode are used only when en=1
//   req        : request vector, bit i = line i is requesting
//   mode       : 0 = fixed priority (highest index wins), 1 = round-robin
//   out_valid  : one-cycle pulse, the sampled req was non-zero
//   out_none   : one-cycle pulse, the sampled req was all-zero
//   out_idx    : index of the last granted line
//   out_onehot : one-hot form of out_idx (all-zero only after reset)
//
// Flow control: each en=1 cycle is one sample and its result appears on the
// outputs one cycle later. There is no back-pressure, so the consumer must
// accept a result on every cycle in which out_valid or out_none is high.
module prio_encoder_rr #(
  parameter int N = 8
) (
  input  logic                 clk,
  input  logic                 rst,
  input  logic                 en,
  input  logic [N-1:0]         req,
  input  logic                 mode,
  output logic                 out_valid,
  output logic                 out_none,
  output logic [$clog2(N)-1:0] out_idx,
  output logic [N-1:0]         out_onehot
);

  import encoder_pkg::*;

  localparam int            W     = $clog2(N);
  localparam logic [W-1:0]  LAST  = W'(N - 1);
  localparam logic [W:0]    N_EXT = (W + 1)'(N);

  // Round-robin pointer: the first line examined on the next sample.
  logic [W-1:0] ptr;
  logic [W-1:0] ptr_next;

  // Datapath
  logic [W-1:0] ptr_eff;    // pointer actually used for this sample
  logic [W-1:0] base;       // req line that lands on rotated bit 0
  logic [N-1:0] rot_req;    // req rotated so that ptr_eff sits at bit N-1
  logic [W-1:0] scan_idx;
  logic         scan_any;
  logic [W-1:0] grant_idx;
  logic [N-1:0] grant_oh;

  // (a + b) mod N for operands in 0..N-1. The sum is at most 2N-2, so a
  // single conditional subtract is enough.
  function automatic logic [W-1:0] add_mod(input logic [W-1:0] a,
                                           input logic [W-1:0] b);
    logic [W:0] s;
    s = {1'b0, a} + {1'b0, b};
    if (s >= N_EXT) s = s - N_EXT;
    return s[W-1:0];
  endfunction

  // Fixed mode reuses the round-robin scan with the pointer pinned to N-1.
  // With that pointer the rotation is the identity and the scan returns
  // the highest set index directly.
  always_comb begin
    ptr_eff = (mode == MODE_FIXED) ? LAST : ptr;
    base    = (ptr_eff == LAST) ? '0 : ptr_eff + 1'b1;
    rot_req = '0;
    // rot_req[j] = req[(ptr_eff + 1 + j) mod N], so rot_req[N-1] = req[ptr_eff].
    // Scanning rot_req downward from N-1 visits ptr_eff, ptr_eff-1, ... with
    // wrap, which is the round-robin search order.
    for (int j = 0; j < N; j++) begin
      rot_req[j] = req[add_mod(base, W'(j))];
    end
  end

  prio_scan #(
    .N (N)
  ) u_scan (
    .in_vec (rot_req),
    .idx    (scan_idx),
    .any    (scan_any)
  );

  // Map the position in the rotated vector back to a real line number.
  always_comb begin
    grant_idx           = add_mod(base, scan_idx);
    grant_oh            = '0;
    grant_oh[grant_idx] = 1'b1;
  end

  // Pointer update. Any fixed-mode sample re-arms the pointer at N-1, so the
  // first round-robin grant after it matches the fixed-priority answer.
  // Empty samples and idle cycles leave the pointer alone.
  always_comb begin
    ptr_next = ptr;
    if (en) begin
      if (mode == MODE_FIXED) begin
        ptr_next = LAST;
      end else if (scan_any) begin
        ptr_next = W'(wrap_dec(32'(grant_idx), N));
      end
    end
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      ptr        <= LAST;
      out_valid  <= 1'b0;
      out_none   <= 1'b0;
      out_idx    <= '0;
      out_onehot <= '0;
    end else begin
      ptr       <= ptr_next;
      out_valid <= en & scan_any;
      out_none  <= en & ~scan_any;
      // An empty sample reports out_none but keeps the previous grant.
      if (en && scan_any) begin
        out_idx    <= grant_idx;
        out_onehot <= grant_oh;
      end
    end
  end

endmodule

// File: tb/tb_prio_encoder_rr.sv
// tb_prio_encoder_rr
// Bench for prio_encoder_rr. It runs an N=8 and an N=5 instance side by side
// and compares them against a search-order reference model on every cycle.
module tb_prio_encoder_rr;

  // ---------------- clock / reset ----------------
  logic clk = 1'b0;
  logic rst = 1'b1;
  always #5 clk = ~clk;

  int checks   = 0;
  int failures = 0;

  // ---------------- DUT signals ----------------
  logic       en8 = 1'b0, mode8 = 1'b0;
  logic [7:0] req8 = '0;
  logic       v8, n8;
  logic [2:0] idx8;
  logic [7:0] oh8;

  logic       en5 = 1'b0, mode5 = 1'b0;
  logic [4:0] req5 = '0;
  logic       v5, n5;
  logic [2:0] idx5;
  logic [4:0] oh5;

  prio_encoder_rr #(.N(8)) u8 (
    .clk(clk), .rst(rst), .en(en8), .req(req8), .mode(mode8),
    .out_valid(v8), .out_none(n8), .out_idx(idx8), .out_onehot(oh8)
  );

  prio_encoder_rr #(.N(5)) u5 (
    .clk(clk), .rst(rst), .en(en5), .req(req5), .mode(mode5),
    .out_valid(v5), .out_none(n5), .out_idx(idx5), .out_onehot(oh5)
  );

  // ---------------- reference model ----------------
  // Slot 0 models the N=8 instance, slot 1 the N=5 instance.
  int         m_ptr  [2];
  int         m_idx  [2];
  logic [7:0] m_oh   [2];
  logic       m_val  [2];
  logic       m_none [2];

  task automatic model_reset();
    m_ptr[0] = 7;
    m_ptr[1] = 4;
    for (int d = 0; d < 2; d++) begin
      m_idx[d]  = 0;
      m_oh[d]   = '0;
      m_val[d]  = 1'b0;
      m_none[d] = 1'b0;
    end
  endtask

  // One sample: walk the lines in search order and take the first requester.
  task automatic model_step(input int d, input int n, input logic [7:0] r,
                            input logic m, input logic e);
    int start;
    int g;
    g = -1;
    if (!e) begin
      m_val[d]  = 1'b0;
      m_none[d] = 1'b0;
    end else begin
      start = m ? m_ptr[d] : n - 1;
      for (int k = 0; k < n; k++) begin
        int i;
        i = (start - k + n) % n;
        if (g < 0 && r[i]) g = i;
      end
      if (g < 0) begin
        m_val[d]  = 1'b0;
        m_none[d] = 1'b1;
      end else begin
        m_val[d]  = 1'b1;
        m_none[d] = 1'b0;
        m_idx[d]  = g;
        m_oh[d]   = 8'(1) << g;
      end
      if (!m)          m_ptr[d] = n - 1;
      else if (g >= 0) m_ptr[d] = (g + n - 1) % n;
    end
  endtask

  // ---------------- scoreboard ----------------
  task automatic chk(input string tag, input logic [31:0] obs,
                     input logic [31:0] exp);
    checks++;
    assert (obs === exp) else begin
      failures++;
      $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask

  task automatic check_outputs();
    chk("v8",    v8,   m_val[0]);
    chk("n8",    n8,   m_none[0]);
    chk("idx8",  idx8, m_idx[0]);
    chk("oh8",   oh8,  m_oh[0]);
    chk("v5",    v5,   m_val[1]);
    chk("n5",    n5,   m_none[1]);
    chk("idx5",  idx5, m_idx[1]);
    chk("oh5",   oh5,  m_oh[1][4:0]);
    chk("range5", (idx5 < 3'd5), 1'b1);
  endtask

  // ---------------- driver tasks ----------------
  // Inputs change on the falling edge; outputs are checked 1 time unit after
  // the rising edge that sampled them.
  task automatic tick();
    @(posedge clk);
    model_step(0, 8, req8, mode8, en8);
    model_step(1, 5, {3'b000, req5}, mode5, en5);
    #1;
    check_outputs();
    @(negedge clk);
  endtask

  task automatic reset_pulse(input string tag);
    rst = 1'b1;
    #1;
    chk({tag, "_v8"},  v8,   1'b0);
    chk({tag, "_n8"},  n8,   1'b0);
    chk({tag, "_i8"},  idx8, 3'd0);
    chk({tag, "_o8"},  oh8,  8'h00);
    chk({tag, "_i5"},  idx5, 3'd0);
    chk({tag, "_o5"},  oh5,  5'h00);
    model_reset();
    #1;
    rst = 1'b0;
  endtask

  task automatic rr8(input string tag, input int exp_idx);
    mode8 = 1'b1; en8 = 1'b1; req8 = 8'hFF;
    tick();
    chk(tag, idx8, exp_idx);
  endtask

  task automatic rr5(input string tag, input logic [4:0] r, input int exp_idx);
    mode5 = 1'b1; en5 = 1'b1; req5 = r;
    tick();
    chk(tag, idx5, exp_idx);
    chk({tag, "_v"}, v5, 1'b1);
  endtask

  // ---------------- stimulus ----------------
  initial begin
    model_reset();
    #1;
    chk("rst_v8", v8,  1'b0);
    chk("rst_n8", n8,  1'b0);
    chk("rst_i8", idx8, 3'd0);
    chk("rst_o8", oh8, 8'h00);
    @(negedge clk);
    rst = 1'b0;

    // Fixed walk: one-hot requests map straight to their index.
    mode8 = 1'b0; en8 = 1'b1;
    for (int i = 0; i < 8; i++) begin
      req8 = 8'(1) << i;
      tick();
      chk("fw_idx", idx8, i);
      chk("fw_v",   v8,   1'b1);
    end
    req8 = 8'b0110_0000;
    tick();
    chk("fw_ovl_idx", idx8, 3'd6);
    chk("fw_ovl_oh",  oh8,  8'h40);

    // No-request and idle.
    req8 = 8'h00;
    tick();
    chk("none_n", n8,   1'b1);
    chk("none_v", v8,   1'b0);
    chk("none_i", idx8, 3'd6);
    en8 = 1'b0;
    tick();
    chk("idle_n", n8,   1'b0);
    chk("idle_v", v8,   1'b0);
    chk("idle_i", idx8, 3'd6);

    // Round-robin full rotation: 7,6,...,0,7.
    for (int k = 0; k < 9; k++) rr8("rr_full", (15 - k) % 8);

    // Grant 6 then 5, then a fixed sample re-arms the pointer.
    rr8("rr_to6", 6);
    rr8("rr_to5", 5);
    mode8 = 1'b0; req8 = 8'hFF;
    tick();
    chk("ms_fixed", idx8, 3'd7);
    rr8("ms_rr0", 7);
    rr8("ms_rr1", 6);

    // Mid-stream reset, then the first sample behaves as after power-up.
    reset_pulse("mid_rst");
    rr8("post_rst", 7);
    en8 = 1'b0;

    // N=5 sparse, then full, checking the wrap to 4.
    rr5("rr5_sp0", 5'b10001, 4);
    rr5("rr5_sp1", 5'b10001, 0);
    rr5("rr5_sp2", 5'b10001, 4);
    rr5("rr5_sp3", 5'b10001, 0);
    rr5("rr5_f0", 5'h1F, 4);
    rr5("rr5_f1", 5'h1F, 3);
    rr5("rr5_f2", 5'h1F, 2);
    rr5("rr5_f3", 5'h1F, 1);
    rr5("rr5_f4", 5'h1F, 0);
    rr5("rr5_f5", 5'h1F, 4);

    // Randomized traffic on both instances against the model.
    for (int c = 0; c < 400; c++) begin
      en8   = ($urandom_range(0, 7) != 0);
      en5   = ($urandom_range(0, 7) != 0);
      mode8 = ($urandom_range(0, 3) != 0);
      mode5 = ($urandom_range(0, 3) != 0);
      case ($urandom_range(0, 3))
        0:       req8 = 8'h00;
        1:       req8 = 8'(1) << $urandom_range(0, 7);
        2:       req8 = 8'($urandom);
        default: req8 = 8'hFF;
      endcase
      case ($urandom_range(0, 3))
        0:       req5 = 5'h00;
        1:       req5 = 5'(1) << $urandom_range(0, 4);
        2:       req5 = 5'($urandom);
        default: req5 = 5'h1F;
      endcase
      if ($urandom_range(0, 99) == 0) reset_pulse("rnd_rst");
      tick();
    end

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
